pulse_feedback_scheduler: RTL

Sequences the pulse-statistics datapath into fixed measurement windows for the servo/feedback path. It opens a window while machining and closes it after WINDOW_CYCLES. It waits for the rate dividers to settle, snapshots the four pulse rates, and offers the snapshot to the servo controller over a valid/ready handshake. It then pulses feedback_finished to clear the statistics counters and divider pipelines before the next window.

---
 rtl/pulse_feedback_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/pulse_feedback_scheduler.sv
// rtl/pulse_feedback_scheduler.sv - measurement-window sequencer for the servo feedback path
module pulse_feedback_scheduler #(
  parameter int WINDOW_CYCLES  = 100000,
  parameter int DIV_LATENCY    = 16,
  parameter int CLEAR_CYCLES   = 2,
  parameter int OVERRUN_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       is_machine,
  input  logic [7:0] normal_pulse_rate,
  input  logic [7:0] arc_pulse_rate,
  input  logic [7:0] open_pulse_rate,
  input  logic [7:0] short_pulse_rate,
  output logic       feedback_finished,
  output logic       fb_valid,
  input  logic       fb_ready,
  output logic [7:0] fb_normal_rate,
  output logic [7:0] fb_arc_rate,
  output logic [7:0] fb_open_rate,
  output logic [7:0] fb_short_rate,
  output logic       fb_invalid,
  output logic [7:0] fb_window_id,
  output logic       fb_overrun
);

  // Each counter only has to reach the last cycle of its phase, so it is
  // sized for that terminal value (never narrower than one bit).
  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int SET_W = (DIV_LATENCY > 0) ? $clog2(DIV_LATENCY + 1) : 1;
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int OVR_W = (OVERRUN_CYCLES > 1) ? $clog2(OVERRUN_CYCLES) : 1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(DIV_LATENCY);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [OVR_W-1:0] OVR_LAST = OVR_W'(OVERRUN_CYCLES - 1);

  localparam logic [7:0] RATE_INVALID = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_SETTLE,
    S_PRESENT,
    S_CLEAR
  } state_t;

  state_t state_q, state_d;

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;

  logic       finished_d;
  logic       valid_d;
  logic [7:0] normal_d;
  logic [7:0] arc_d;
  logic [7:0] open_d;
  logic [7:0] short_d;
  logic       invalid_d;
  logic [7:0] window_id_d;
  logic       overrun_d;

  logic       any_rate_invalid;

  assign any_rate_invalid = (normal_pulse_rate == RATE_INVALID) ||
                            (arc_pulse_rate    == RATE_INVALID) ||
                            (open_pulse_rate   == RATE_INVALID) ||
                            (short_pulse_rate  == RATE_INVALID);

  // Register the phase, its counters and every output so nothing on the
  // feedback interface is a combinational function of the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      win_cnt_q         <= '0;
      set_cnt_q         <= '0;
      clr_cnt_q         <= '0;
      ovr_cnt_q         <= '0;
      feedback_finished <= 1'b1;
      fb_valid          <= 1'b0;
      fb_normal_rate    <= 8'd0;
      fb_arc_rate       <= 8'd0;
      fb_open_rate      <= 8'd0;
      fb_short_rate     <= 8'd0;
      fb_invalid        <= 1'b0;
      fb_window_id      <= 8'd0;
      fb_overrun        <= 1'b0;
    end else begin
      state_q           <= state_d;
      win_cnt_q         <= win_cnt_d;
      set_cnt_q         <= set_cnt_d;
      clr_cnt_q         <= clr_cnt_d;
      ovr_cnt_q         <= ovr_cnt_d;
      feedback_finished <= finished_d;
      fb_valid          <= valid_d;
      fb_normal_rate    <= normal_d;
      fb_arc_rate       <= arc_d;
      fb_open_rate      <= open_d;
      fb_short_rate     <= short_d;
      fb_invalid        <= invalid_d;
      fb_window_id      <= window_id_d;
      fb_overrun        <= overrun_d;
    end
  end

  // Walk one window: accumulate, let the dividers settle, present the
  // snapshot, then strobe the clear before the next window.
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    set_cnt_d   = set_cnt_q;
    clr_cnt_d   = clr_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    valid_d     = fb_valid;
    normal_d    = fb_normal_rate;
    arc_d       = fb_arc_rate;
    open_d      = fb_open_rate;
    short_d     = fb_short_rate;
    invalid_d   = fb_invalid;
    window_id_d = fb_window_id;
    overrun_d   = fb_overrun;

    case (state_q)
      S_IDLE: begin
        if (is_machine) begin
          state_d   = S_ACCUM;
          win_cnt_d = '0;
        end
      end

      S_ACCUM: begin
        // Losing the machining enable abandons the partial window, even on
        // its final cycle.
        if (!is_machine) begin
          state_d = S_IDLE;
        end else if (win_cnt_q == WIN_LAST) begin
          state_d   = S_SETTLE;
          set_cnt_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
        end
      end

      S_SETTLE: begin
        // The last settle cycle covers the divider pipeline plus its output
        // register, so the rates seen here belong to the closed window.
        if (!is_machine) begin
          state_d = S_IDLE;
        end else if (set_cnt_q == SET_LAST) begin
          state_d   = S_PRESENT;
          ovr_cnt_d = '0;
          valid_d   = 1'b1;
          normal_d  = normal_pulse_rate;
          arc_d     = arc_pulse_rate;
          open_d    = open_pulse_rate;
          short_d   = short_pulse_rate;
          invalid_d = any_rate_invalid;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end

      S_PRESENT: begin
        // The snapshot stays up regardless of is_machine; only the consumer
        // or the overrun timer retires it. A handshake on the final cycle
        // wins over the timeout.
        if (fb_ready) begin
          state_d     = S_CLEAR;
          clr_cnt_d   = '0;
          valid_d     = 1'b0;
          window_id_d = fb_window_id + 8'd1;
        end else if (ovr_cnt_q == OVR_LAST) begin
          state_d     = S_CLEAR;
          clr_cnt_d   = '0;
          valid_d     = 1'b0;
          window_id_d = fb_window_id + 8'd1;
          overrun_d   = 1'b1;
        end else begin
          ovr_cnt_d = ovr_cnt_q + 1'b1;
        end
      end

      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          if (is_machine) begin
            state_d   = S_ACCUM;
            win_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The statistics block is held cleared whenever no window is open and
    // for the clear strobe between windows.
    finished_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
  end

endmodule
